// File: rtl/nt_node_event_monitor_pkg.sv
// nt_monitor_pkg: shared FSM state type and default parameters for the Nt-node event monitor
package nt_monitor_pkg;
  typedef enum logic [1:0] {S0, S1, S2, S3} pat_state_t;
  localparam int CNT_W_DEF = 8;
  localparam int WIN_LEN_DEF = 16;
  localparam int THRESH_DEF = 4;
endpackage

// File: rtl/nt_node_event_monitor_if.sv
// nt_node_event_monitor_if: node input, control strobes and event flags of the monitor
interface nt_node_event_monitor_if
  import nt_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic I4130;
  logic I4131;
  logic I4132;
  logic I4150;
  logic I4151;
  logic [CNT_W-1:0] I4152;
  logic I4153;
  modport master (output I4130, I4131, I4132, input I4150, I4151, I4152, I4153);
  modport slave (input I4130, I4131, I4132, output I4150, I4151, I4152, I4153);
endinterface

// File: rtl/nt_node_event_monitor_edge_window_counter.sv
// nt_edge_window_counter: per-window rising-edge counter with one-shot threshold pulse
module nt_edge_window_counter
  import nt_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic rise,
  output logic [CNT_W-1:0] edge_cnt,
  output logic thr_hit
);
  localparam int WIN_W = $clog2(WIN_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] THR_PRE = CNT_W'(THRESH - 1);
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic wrap;
  // A rise on the wrap cycle opens the new window, so it restarts the count at 1
  always_comb begin
    wrap = win_cnt == WIN_LAST;
    win_nxt = wrap ? '0 : win_cnt + 1'b1;
    cnt_nxt = wrap ? CNT_W'(rise) : (rise && edge_cnt != CNT_MAX) ? edge_cnt + 1'b1 : edge_cnt;
  end
  // Threshold fires only on the THRESH-1 -> THRESH step, so saturation cannot re-fire it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      edge_cnt <= '0;
      thr_hit <= 1'b0;
    end else if (clr) begin
      win_cnt <= '0;
      edge_cnt <= '0;
      thr_hit <= 1'b0;
    end else if (en) begin
      win_cnt <= win_nxt;
      edge_cnt <= cnt_nxt;
      thr_hit <= edge_cnt == THR_PRE && cnt_nxt == THR;
    end else begin
      thr_hit <= 1'b0;
    end
  end
endmodule

// File: rtl/nt_node_event_monitor.sv
// nt_node_event_monitor: registers node I4130, counts its rises per window and detects 1-0-1-1
module nt_node_event_monitor
  import nt_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input logic I1470,
  input logic I1477,
  nt_node_event_monitor_if.slave bus
);
  logic node_q;
  logic node_qq;
  logic rise;
  logic pat_hit;
  logic pat_nxt;
  logic thr_hit;
  logic [CNT_W-1:0] edge_cnt;
  pat_state_t state;
  pat_state_t state_nxt;
  assign rise = node_q & ~node_qq;
  // Two-stage sampling of the node; the second stage only serves rise detection
  always_ff @(posedge I1470 or negedge I1477) begin
    if (!I1477) begin
      node_q <= 1'b0;
      node_qq <= 1'b0;
    end else if (bus.I4132) begin
      node_q <= 1'b0;
      node_qq <= 1'b0;
    end else if (bus.I4131) begin
      node_q <= bus.I4130;
      node_qq <= node_q;
    end
  end
  // Pattern state register; the hit flag is a pulse and drops on any non-enabled cycle
  always_ff @(posedge I1470 or negedge I1477) begin
    if (!I1477) begin
      state <= S0;
      pat_hit <= 1'b0;
    end else if (bus.I4132) begin
      state <= S0;
      pat_hit <= 1'b0;
    end else if (bus.I4131) begin
      state <= state_nxt;
      pat_hit <= pat_nxt;
    end else begin
      pat_hit <= 1'b0;
    end
  end
  // Overlapping 1-0-1-1 matcher on node_q; each state is the longest matched prefix
  always_comb begin
    state_nxt = state;
    pat_nxt = 1'b0;
    case (state)
      S0: state_nxt = node_q ? S1 : S0;
      S1: state_nxt = node_q ? S1 : S2;
      S2: state_nxt = node_q ? S3 : S0;
      S3: begin
        state_nxt = node_q ? S1 : S2;
        pat_nxt = node_q;
      end
      default: state_nxt = S0;
    endcase
  end
  nt_edge_window_counter #(
    .CNT_W(CNT_W),
    .WIN_LEN(WIN_LEN),
    .THRESH(THRESH)
  ) u_cnt (
    .clk(I1470),
    .rst_n(I1477),
    .clr(bus.I4132),
    .en(bus.I4131),
    .rise(rise),
    .edge_cnt(edge_cnt),
    .thr_hit(thr_hit)
  );
  assign bus.I4150 = pat_hit;
  assign bus.I4151 = thr_hit;
  assign bus.I4152 = edge_cnt;
  assign bus.I4153 = node_q;
endmodule

// File: tb/tb_nt_node_event_monitor.sv
// tb_nt_node_event_monitor: scoreboard bench for two monitor configurations driven in lockstep
module tb_nt_node_event_monitor;
  typedef struct {
    bit pat;
    bit thr;
    int cnt;
    bit nq;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  nt_node_event_monitor_if #(.CNT_W(8)) b0 ();
  nt_node_event_monitor_if #(.CNT_W(3)) b1 ();
  nt_node_event_monitor #(.CNT_W(8), .WIN_LEN(16), .THRESH(4)) d0 (.I1470(clk), .I1477(rst_n), .bus(b0));
  nt_node_event_monitor #(.CNT_W(3), .WIN_LEN(64), .THRESH(4)) d1 (.I1470(clk), .I1477(rst_n), .bus(b1));
  exp_t sb[$];
  exp_t e0, e1;
  int checks = 0;
  int failures = 0;
  int pat_seen = 0;
  int thr_seen = 0;
  bit s1, s2;
  bit hist[$];
  int cnt[2];
  int pos[2];
  int wl[2] = '{16, 64};
  int mx[2] = '{255, 7};
  task automatic chk(string name, logic [31:0] act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_reset();
    s1 = 0;
    s2 = 0;
    hist.delete();
    cnt = '{0, 0};
    pos = '{0, 0};
  endtask
  task automatic step(bit in, bit en, bit clr);
    exp_t e[2];
    bit rise, pat;
    int old;
    @(negedge clk);
    b0.I4130 = in; b0.I4131 = en; b0.I4132 = clr;
    b1.I4130 = in; b1.I4131 = en; b1.I4132 = clr;
    @(posedge clk);
    e[0] = '{0, 0, 0, 0};
    e[1] = '{0, 0, 0, 0};
    if (!rst_n || clr) model_reset();
    else if (en) begin
      rise = s1 && !s2;
      hist.push_back(s1);
      if (hist.size() > 4) void'(hist.pop_front());
      pat = hist.size() == 4 && hist[0] && !hist[1] && hist[2] && hist[3];
      for (int i = 0; i < 2; i++) begin
        old = cnt[i];
        if (pos[i] == wl[i] - 1) begin
          cnt[i] = int'(rise);
          pos[i] = 0;
        end else begin
          cnt[i] = (cnt[i] + int'(rise) > mx[i]) ? mx[i] : cnt[i] + int'(rise);
          pos[i]++;
        end
        e[i].thr = old == 3 && cnt[i] == 4;
        e[i].pat = pat;
      end
      s2 = s1;
      s1 = in;
    end
    for (int i = 0; i < 2; i++) begin
      e[i].cnt = cnt[i];
      e[i].nq = s1;
      sb.push_back(e[i]);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() >= 2) begin
      e0 = sb.pop_front();
      e1 = sb.pop_front();
      chk("pat0", b0.I4150, int'(e0.pat));
      chk("thr0", b0.I4151, int'(e0.thr));
      chk("cnt0", b0.I4152, e0.cnt);
      chk("nq0", b0.I4153, int'(e0.nq));
      chk("pat1", b1.I4150, int'(e1.pat));
      chk("thr1", b1.I4151, int'(e1.thr));
      chk("cnt1", b1.I4152, e1.cnt);
      chk("nq1", b1.I4153, int'(e1.nq));
      pat_seen += int'(b0.I4150);
      thr_seen += int'(b0.I4151);
    end
  end
  initial begin
    int p;
    bit seq[7] = '{1, 0, 1, 1, 0, 1, 1};
    b0.I4130 = 0; b0.I4131 = 0; b0.I4132 = 0;
    b1.I4130 = 0; b1.I4131 = 0; b1.I4132 = 0;
    model_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    #2 rst_n = 1'b1;
    p = pat_seen;
    foreach (seq[i]) step(seq[i], 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    #2 chk("pattern_count", pat_seen - p, 2);
    step(0, 1, 1);
    p = thr_seen;
    repeat (5) begin
      step(1, 1, 0);
      step(0, 1, 0);
    end
    step(0, 1, 0);
    step(0, 1, 0);
    #2 chk("thr_count", thr_seen - p, 1);
    chk("cnt_after5", b0.I4152, 5);
    repeat (40) begin
      step(1, 1, 0);
      step(0, 1, 0);
    end
    step(0, 1, 1);
    repeat (3) begin
      step(1, 1, 0);
      step(0, 1, 0);
    end
    repeat (8) step(0, 1, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    #2 chk("wrap_cnt", b0.I4152, 1);
    repeat (5) step(1'($urandom % 2), 0, 0);
    step(1, 1, 1);
    #2 chk("clr_cnt", b0.I4152, 0);
    chk("clr_nq", b0.I4153, 0);
    repeat (3) begin
      step(1, 1, 0);
      step(0, 1, 0);
    end
    #3 rst_n = 1'b0;
    #1 chk("rst_cnt0", b0.I4152, 0);
    chk("rst_nq0", b0.I4153, 0);
    chk("rst_pat0", b0.I4150, 0);
    chk("rst_thr0", b0.I4151, 0);
    chk("rst_cnt1", b1.I4152, 0);
    model_reset();
    step(1, 1, 0);
    step(0, 1, 0);
    #2 rst_n = 1'b1;
    step(1, 1, 0);
    step(0, 1, 0);
    #2 chk("first_rise_after_rst", b0.I4152, 1);
    repeat (3000) step(1'($urandom % 2), 1'(($urandom % 10) != 0), 1'(($urandom % 50) == 0));
    #2 chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
